// File: rtl/layer_maxpool_2x2.sv
// Streaming 2x2 stride-2 FP32 max-pool over one raster-order feature map.
// Half-row line buffer holds top-row pair maxima until the bottom row arrives.
module layer_maxpool_2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 208
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
);

    localparam int CW       = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 2;
    localparam int LB_DEPTH = IMG_SIZE / 2;
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    // Sign-magnitude float mapped onto an unsigned-monotonic key; -0.0 sorts below +0.0.
    function automatic logic [DATA_WIDTH-1:0] fp_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        return (fp_key(a) >= fp_key(b)) ? a : b;
    endfunction

    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] pair_q, pair_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    logic [DATA_WIDTH-1:0] linebuf [LB_DEPTH];
    logic [CW-2:0]         lb_idx;
    logic                  lb_we;
    logic [DATA_WIDTH-1:0] top_max;
    logic [DATA_WIDTH-1:0] win_max;

    assign lb_idx  = col_q[CW-1:1];
    // Earlier operand goes first so ties keep the earlier-arriving value.
    assign top_max = fp_max(pair_q, data_in);
    assign win_max = fp_max(linebuf[lb_idx], top_max);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        lb_we       = 1'b0;
        if (valid_in) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (!col_q[0]) begin
                pair_d = data_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                data_out_d  = win_max;
                valid_out_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge Clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= top_max;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_layer_maxpool_2x2.sv
// Randomized and directed bench for layer_maxpool_2x2 at IMG_SIZE 4 and 208,
// checked against a frame-array window-max reference model.
module tb_layer_maxpool_2x2;

    localparam int SW = 4;
    localparam int BW = 208;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        vin_s = 1'b0;
    logic        vin_b = 1'b0;
    logic [31:0] dout_s, dout_b;
    logic        vout_s, vout_b;

    always #5 clk = ~clk;

    layer_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(SW)) dut_s (
        .Clk(clk), .Rst(rst), .data_in(din), .valid_in(vin_s),
        .data_out(dout_s), .valid_out(vout_s));

    layer_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(BW)) dut_b (
        .Clk(clk), .Rst(rst), .data_in(din), .valid_in(vin_b),
        .data_out(dout_b), .valid_out(vout_b));

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          sel      = 1'b0;
    logic [31:0] img [BW*BW];
    int          idx      = 0;
    logic [31:0] last_out = '0;
    logic [31:0] got_q [$];
    int          strobes  = 0;
    logic [31:0] exp4 [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Total order on non-NaN floats: larger magnitude positive is bigger,
    // larger magnitude negative is smaller, -0.0 below +0.0.
    function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic logic [31:0] max4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] w [4];
        logic [31:0] best;
        w = '{a, b, c, d};
        best = w[0];
        for (int i = 1; i < 4; i++) if (fp_gt(w[i], best)) best = w[i];
        return best;
    endfunction

    function automatic logic [31:0] itof(input int n);
        int e;
        logic [31:0] m;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = (32'(n) << (23 - e)) & 32'h007FFFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(7) == 0) begin
            case ($urandom_range(3))
                0: r = 32'h00000000;
                1: r = 32'h80000000;
                2: r = 32'h3F800000;
                default: r = 32'hBF800000;
            endcase
        end
        if (r[30:23] == 8'hFF) r[30:23] = 8'hFE;
        return r;
    endfunction

    task automatic step(input bit v, input logic [31:0] d);
        int w, r, c;
        logic        exp_vld;
        logic        obs_v;
        logic [31:0] obs_d;
        @(negedge clk);
        din   = d;
        vin_s = v && !sel;
        vin_b = v && sel;
        @(posedge clk);
        #1;
        exp_vld = 1'b0;
        if (v) begin
            w = sel ? BW : SW;
            r = idx / w;
            c = idx % w;
            img[idx] = d;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                last_out = max4(img[idx-w-1], img[idx-w], img[idx-1], d);
                exp_vld  = 1'b1;
            end
            idx = (idx + 1 == w * w) ? 0 : idx + 1;
        end
        obs_v = sel ? vout_b : vout_s;
        obs_d = sel ? dout_b : dout_s;
        chk("valid_out", {31'b0, obs_v}, {31'b0, exp_vld});
        chk("data_out", obs_d, last_out);
        if (obs_v) begin
            got_q.push_back(obs_d);
            strobes++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        vin_s = 1'b0;
        vin_b = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_vld_s", {31'b0, vout_s}, 32'd0);
        chk("rst_dat_s", dout_s, 32'd0);
        chk("rst_vld_b", {31'b0, vout_b}, 32'd0);
        chk("rst_dat_b", dout_b, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        idx      = 0;
        last_out = '0;
        strobes  = 0;
        got_q.delete();
    endtask

    task automatic check_pool4(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk(tag, got_q[i], exp4[i]);
    endtask

    initial begin
        logic [31:0] wframe [16];
        wframe = '{32'hC0400000, 32'hBF800000, 32'h80000000, 32'h00000000,
                   32'hC0000000, 32'hC0A00000, 32'hBF800000, 32'h80000000,
                   32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                   32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

        sel = 1'b0;
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, itof(i));
        step(1'b0, 32'd0);
        check_pool4("cont");

        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, wframe[i]);
        step(1'b0, 32'd0);
        chk("neg_win", got_q.size() > 0 ? got_q[0] : 32'hDEADBEEF, 32'hBF800000);
        chk("zero_win", got_q.size() > 1 ? got_q[1] : 32'hDEADBEEF, 32'h00000000);

        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, itof(i));
            step(1'b0, 32'd0);
        end
        check_pool4("gap");

        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, itof(i));
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, itof(i));
        step(1'b0, 32'd0);
        check_pool4("abort");

        sel = 1'b1;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < BW * BW; i++) step(1'b1, rnd_fp());
            chk("frame_outputs", 32'(strobes), 32'd10816);
            strobes = 0;
        end
        step(1'b0, 32'd0);
        step(1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
